// File: rtl/c432_ipff.sv
// 27-request, 9-channel priority interrupt controller (c432 function) with registered inputs.
// Define C432_OUTREG_EN to also register the seven outputs (latency 2 clk instead of 1).
module c432_ipff (
  input  logic clk,
  input  logic reset_n,
  input  logic PCN1,
  input  logic PCN4,
  input  logic PCN8,
  input  logic PCN11,
  input  logic PCN14,
  input  logic PCN17,
  input  logic PCN21,
  input  logic PCN24,
  input  logic PCN27,
  input  logic PCN30,
  input  logic PCN34,
  input  logic PCN37,
  input  logic PCN40,
  input  logic PCN43,
  input  logic PCN47,
  input  logic PCN50,
  input  logic PCN53,
  input  logic PCN56,
  input  logic PCN60,
  input  logic PCN63,
  input  logic PCN66,
  input  logic PCN69,
  input  logic PCN73,
  input  logic PCN76,
  input  logic PCN79,
  input  logic PCN82,
  input  logic PCN86,
  input  logic PCN89,
  input  logic PCN92,
  input  logic PCN95,
  input  logic PCN99,
  input  logic PCN102,
  input  logic PCN105,
  input  logic PCN108,
  input  logic PCN112,
  input  logic PCN115,
  output logic Qout_PCN_223,
  output logic Qout_PCN_329,
  output logic Qout_PCN_370,
  output logic Qout_PCN_421,
  output logic Qout_PCN_430,
  output logic Qout_PCN_431,
  output logic Qout_PCN_432
);

  logic [35:0] raw_in;
  logic [35:0] in_reg;
  logic [8:0]  en;
  logic [8:0]  req_a;
  logic [8:0]  req_b;
  logic [8:0]  req_c;
  logic        pa;
  logic        pb;
  logic        pc;
  logic [8:0]  win;
  logic [3:0]  chan;

  // Bit 4*i+k holds E/A/B/C (k=0..3) of channel i.
  assign raw_in = {PCN115, PCN112, PCN108, PCN105, PCN102, PCN99,  PCN95,  PCN92,  PCN89,
                   PCN86,  PCN82,  PCN79,  PCN76,  PCN73,  PCN69,  PCN66,  PCN63,  PCN60,
                   PCN56,  PCN53,  PCN50,  PCN47,  PCN43,  PCN40,  PCN37,  PCN34,  PCN30,
                   PCN27,  PCN24,  PCN21,  PCN17,  PCN14,  PCN11,  PCN8,   PCN4,   PCN1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_reg <= '0;
    end else begin
      in_reg <= raw_in;
    end
  end

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_chan
      assign en[gi]    = in_reg[4*gi];
      assign req_a[gi] = in_reg[4*gi+1] & en[gi];
      assign req_b[gi] = in_reg[4*gi+2] & en[gi];
      assign req_c[gi] = in_reg[4*gi+3] & en[gi];
    end
  endgenerate

  always_comb begin
    pa  = |req_a;
    pb  = ~pa & (|req_b);
    pc  = ~pa & ~pb & (|req_c);
    win = pa ? req_a : (pb ? req_b : req_c);
    // Scan downward so the lowest set index is the last one written.
    chan = 4'hF;
    for (int i = 8; i >= 0; i--) begin
      if (win[i]) chan = 4'(i);
    end
  end

`ifdef C432_OUTREG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Qout_PCN_223 <= 1'b0;
      Qout_PCN_329 <= 1'b0;
      Qout_PCN_370 <= 1'b0;
      {Qout_PCN_421, Qout_PCN_430, Qout_PCN_431, Qout_PCN_432} <= 4'hF;
    end else begin
      Qout_PCN_223 <= pa;
      Qout_PCN_329 <= pb;
      Qout_PCN_370 <= pc;
      {Qout_PCN_421, Qout_PCN_430, Qout_PCN_431, Qout_PCN_432} <= chan;
    end
  end
`else
  assign Qout_PCN_223 = pa;
  assign Qout_PCN_329 = pb;
  assign Qout_PCN_370 = pc;
  assign {Qout_PCN_421, Qout_PCN_430, Qout_PCN_431, Qout_PCN_432} = chan;
`endif

endmodule

// File: tb/tb_c432_ipff.sv
// Directed self-checking bench for c432_ipff; observed word is {PA,PB,PC,CHAN[3:0]}.
module tb_c432_ipff;

`ifdef C432_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [35:0] vec = '0;
  logic        pa, pb, pc, c3, c2, c1, c0;
  logic [6:0]  obs;
  int          n_checks = 0;
  int          n_fail = 0;

  assign obs = {pa, pb, pc, c3, c2, c1, c0};

  always #5 clk = ~clk;

  c432_ipff dut (
    .clk(clk), .reset_n(reset_n),
    .PCN1(vec[0]),    .PCN4(vec[1]),    .PCN8(vec[2]),    .PCN11(vec[3]),
    .PCN14(vec[4]),   .PCN17(vec[5]),   .PCN21(vec[6]),   .PCN24(vec[7]),
    .PCN27(vec[8]),   .PCN30(vec[9]),   .PCN34(vec[10]),  .PCN37(vec[11]),
    .PCN40(vec[12]),  .PCN43(vec[13]),  .PCN47(vec[14]),  .PCN50(vec[15]),
    .PCN53(vec[16]),  .PCN56(vec[17]),  .PCN60(vec[18]),  .PCN63(vec[19]),
    .PCN66(vec[20]),  .PCN69(vec[21]),  .PCN73(vec[22]),  .PCN76(vec[23]),
    .PCN79(vec[24]),  .PCN82(vec[25]),  .PCN86(vec[26]),  .PCN89(vec[27]),
    .PCN92(vec[28]),  .PCN95(vec[29]),  .PCN99(vec[30]),  .PCN102(vec[31]),
    .PCN105(vec[32]), .PCN108(vec[33]), .PCN112(vec[34]), .PCN115(vec[35]),
    .Qout_PCN_223(pa), .Qout_PCN_329(pb), .Qout_PCN_370(pc),
    .Qout_PCN_421(c3), .Qout_PCN_430(c2), .Qout_PCN_431(c1), .Qout_PCN_432(c0)
  );

  // Field: 0=E, 1=A, 2=B, 3=C
  function automatic logic [35:0] sig(input int ch, input int field);
    logic [35:0] one;
    one = 36'd1;
    return one << (4 * ch + field);
  endfunction

  task automatic drive(input logic [35:0] v);
    @(negedge clk);
    vec = v;
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec = {$urandom, $urandom} | 36'hF_FFFF_FFFF;
      @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 7'b000_1111) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got %b want %b", k, obs, 7'b000_1111);
      end else $display("reset_hold%0d: %b ok", k, obs);
    end
    @(negedge clk);
    vec = '0;
    reset_n = 1'b1;
    drive('0);
    n_checks++;
    if (obs !== 7'b000_1111) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", obs, 7'b000_1111);
    end else $display("reset_release: %b ok", obs);
  endtask

  task automatic test_single_a();
    drive(sig(3, 0) | sig(3, 1));
    n_checks++;
    if (obs !== 7'b100_0011) begin
      n_fail++;
      $display("FAIL single_a_ch3: got %b want %b", obs, 7'b100_0011);
    end else $display("single_a_ch3: %b ok", obs);
  endtask

  task automatic test_a_beats_b();
    drive(sig(0, 0) | sig(0, 2) | sig(5, 0) | sig(5, 1));
    n_checks++;
    if (obs !== 7'b100_0101) begin
      n_fail++;
      $display("FAIL a_beats_b: got %b want %b", obs, 7'b100_0101);
    end else $display("a_beats_b: %b ok", obs);
    drive(sig(1, 0) | sig(1, 3) | sig(6, 0) | sig(6, 2));
    n_checks++;
    if (obs !== 7'b010_0110) begin
      n_fail++;
      $display("FAIL b_beats_c: got %b want %b", obs, 7'b010_0110);
    end else $display("b_beats_c: %b ok", obs);
  endtask

  task automatic test_lowest_c();
    drive(sig(2, 0) | sig(2, 3) | sig(7, 0) | sig(7, 3));
    n_checks++;
    if (obs !== 7'b001_0010) begin
      n_fail++;
      $display("FAIL lowest_c: got %b want %b", obs, 7'b001_0010);
    end else $display("lowest_c: %b ok", obs);
  endtask

  task automatic test_disabled();
    drive(sig(4, 1));
    n_checks++;
    if (obs !== 7'b000_1111) begin
      n_fail++;
      $display("FAIL disabled_a4: got %b want %b", obs, 7'b000_1111);
    end else $display("disabled_a4: %b ok", obs);
    // Disabled A on ch0 must not mask an enabled C on ch8.
    drive(sig(0, 1) | sig(0, 2) | sig(8, 0) | sig(8, 3));
    n_checks++;
    if (obs !== 7'b001_1000) begin
      n_fail++;
      $display("FAIL disabled_vs_c8: got %b want %b", obs, 7'b001_1000);
    end else $display("disabled_vs_c8: %b ok", obs);
  endtask

  task automatic test_channel_sweep();
    logic [6:0] exp_obs;
    for (int ch = 0; ch < 9; ch++) begin
      drive(sig(ch, 0) | sig(ch, 2));
      exp_obs = {3'b010, 4'(ch)};
      n_checks++;
      if (obs !== exp_obs) begin
        n_fail++;
        $display("FAIL sweep_b_ch%0d: got %b want %b", ch, obs, exp_obs);
      end else $display("sweep_b_ch%0d: %b ok", ch, obs);
    end
  endtask

  task automatic test_all_ones_async_reset();
    drive('1);
    n_checks++;
    if (obs !== 7'b100_0000) begin
      n_fail++;
      $display("FAIL all_ones: got %b want %b", obs, 7'b100_0000);
    end else $display("all_ones: %b ok", obs);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 7'b000_1111) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", obs, 7'b000_1111);
    end else $display("async_reset: %b ok", obs);
    @(negedge clk);
    reset_n = 1'b1;
    drive('1);
    n_checks++;
    if (obs !== 7'b100_0000) begin
      n_fail++;
      $display("FAIL after_reset: got %b want %b", obs, 7'b100_0000);
    end else $display("after_reset: %b ok", obs);
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_a_beats_b();
    test_lowest_c();
    test_disabled();
    test_channel_sweep();
    test_all_ones_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
